apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Two-port request arbiter in front of the APB master's internal interface (`transfer`/`ready`/`addr`/`wdata`/`write`/`rdata`). It lets two requesters, the RV32I core data port (port 0) and a second bus requester such as a DMA or debug engine (port 1), share one APB master. Each requester's one-cycle transfer pulse is captured into a per-port request buffer. Buffered requests are issued one at a time with round-robin priority, and each completion is returned to its owner as a one-cycle ready pulse carrying the read data.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, write/read data width

Ports:
- `PCLK` in 1: single clock; all state updates on its rising edge
- `PRESET` in 1: reset, synchronous, active-high
- `req_transfer[1:0]` in 2: per-port one-cycle request pulse
- `req_addr0`, `req_addr1` in ADDR_W: request address, sampled with the pulse
- `req_wdata0`, `req_wdata1` in DATA_W: write data, sampled with the pulse
- `req_write[1:0]` in 2: per-port direction, 1 = write, 0 = read; sampled with the pulse
- `req_ready[1:0]` out 2: per-port one-cycle completion pulse
- `req_rdata` out DATA_W: read data, valid while any `req_ready` bit is high
- `req_busy[1:0]` out 2: port has a buffered or in-flight request
- `req_drop[1:0]` out 2: one-cycle pulse; the request pulse on that port was discarded
- `transfer` out 1: one-cycle start pulse to the APB master
- `addr` out ADDR_W, `wdata` out DATA_W, `write` out 1: request presented to the APB master
- `ready` in 1: APB master completion
- `rdata` in DATA_W: APB master read data, valid with `ready`
- `grant` out 1: index of the port owning the current or last transaction

## Operation
- Per-port buffer: `pend`, `addr`, `wdata`, `write`.
  - `req_transfer[i]` at an edge with `pend[i]=0` loads the buffer and sets `pend[i]`.
  - `req_transfer[i]` with `pend[i]=1` that is not completing at the same edge is discarded. `req_drop[i]` pulses the next cycle; the buffer is unchanged.
- FSM states:
  - IDLE: if any `pend` bit is set, select a port and go to ISSUE.
  - ISSUE: lasts exactly 1 cycle; `transfer=1`. Always go to WAIT.
  - WAIT: hold `addr`/`wdata`/`write`. On `ready=1`, capture `rdata`, clear the granted `pend` bit, and go to IDLE.
- Selection is round-robin on `last`, the port granted most recently:
  - Both ports pending: grant `~last`.
  - One port pending: grant that port.
  - `last` and `grant` update when IDLE moves to ISSUE.
- `addr`, `wdata` and `write` are muxed from the granted buffer. They are stable from ISSUE through the WAIT exit edge.
- Completion: in the cycle after the `ready` edge, `req_ready[grant]=1` for 1 cycle and `req_rdata` = captured data. `req_rdata` holds its value until the next completion.
- A write also produces `req_ready`. `req_rdata` is then whatever the master returned and is don't-care to the requester.
- `ready` in IDLE or ISSUE is ignored.
- `req_busy[i] = pend[i]`.

## Timing
- Reset values: `pend=0`, state IDLE, `last=1` (so port 0 wins the first tie), `grant=0`, and every output 0.
- All outputs are registered or decoded from registers. No input reaches an output combinationally.
- Latency with the arbiter idle, pulse at edge N:
  - `pend`=1 after N.
  - ISSUE (`transfer`=1) in cycle N+2.
  - WAIT from N+3.
  - `ready` seen at edge M gives `req_ready` high in cycle M+1.
  - Next ISSUE no earlier than M+2.
- Simultaneous pulses on both ports at the same edge: both are buffered, and the tie is resolved by `last`.
- Pulse on port i at the same edge that completes port i's request: accepted; the buffer reloads and `pend[i]` stays 1. No drop.
- Pulse on port j while port i is in flight: buffered, and issued after i completes.
- Back-to-back saturation from both ports: grants strictly alternate 0,1,0,1.
- `PRESET` mid-transaction: the arbiter returns to its reset state at that edge. Buffered requests are lost and no `req_ready` is generated for them. The APB master is reset by the same `PRESET`.
- No timeout: WAIT holds indefinitely until `ready`.

## Test plan
- Single read, port 0:
  - Stimulus: pulse at edge 2 with `addr=0x1000_4000`, `write=0`; master returns `ready` with `rdata=0x0000_00A5` three cycles after `transfer`.
  - Required: `transfer` in cycle 4; `addr` held from cycle 4 until `ready`; `req_ready=2'b01` and `req_rdata=0xA5` the cycle after `ready`.
- Simultaneous requests after reset:
  - Stimulus: both ports pulse at the same edge; port 0 writes `0x1000_2000`/`0x55`, port 1 reads `0x1000_3000`.
  - Required: port 0 is issued first with `write=1`, `wdata=0x55`; port 1 is issued second; `req_ready` pulses `2'b01` then `2'b10`.
- Fairness:
  - Stimulus: both ports re-pulse the same cycle their `req_ready` arrives, for 6 transactions.
  - Required: `grant` sequence 0,1,0,1,0,1; no `req_drop`.
- Overflow:
  - Stimulus: port 1 pulses twice, 1 cycle apart, while port 0 is in WAIT.
  - Required: `req_drop=2'b10` one cycle after the second pulse; port 1 issues the first request's address only.
- Reset mid-op:
  - Stimulus: assert `PRESET` during WAIT with port 1 pending.
  - Required: the next cycle shows `pend=0`, IDLE, all outputs 0; later master `ready` pulses produce no `req_ready`.
- Stray `ready`:
  - Stimulus: pulse `ready` while IDLE.
  - Required: no `req_ready`; `req_rdata` unchanged.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: buffers one request per port and issues them to a shared
// APB master one at a time, round-robin, returning each completion to its owner.
module apb_req_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [1:0]        req_transfer,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   input  logic [1:0]        req_write,
   output logic [1:0]        req_ready,
   output logic [DATA_W-1:0] req_rdata,
   output logic [1:0]        req_busy,
   output logic [1:0]        req_drop,
   output logic              transfer,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              write,
   input  logic              ready,
   input  logic [DATA_W-1:0] rdata,
   output logic              grant
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             pend_q, pend_d;
   logic [1:0][ADDR_W-1:0] baddr_q, baddr_d;
   logic [1:0][DATA_W-1:0] bwdata_q, bwdata_d;
   logic [1:0]             bwrite_q, bwrite_d;
   logic                   last_q, last_d;
   logic                   grant_q, grant_d;
   logic [1:0]             rdy_q, rdy_d;
   logic [1:0]             drop_q, drop_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;

   logic [1:0][ADDR_W-1:0] in_addr;
   logic [1:0][DATA_W-1:0] in_wdata;
   logic [1:0]             done;

   assign in_addr  = {req_addr1, req_addr0};
   assign in_wdata = {req_wdata1, req_wdata0};

   // one-hot of the port whose transaction completes at this edge
   assign done = (state_q == S_WAIT && ready) ?
                 (grant_q ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      baddr_d  = baddr_q;
      bwdata_d = bwdata_q;
      bwrite_d = bwrite_q;
      last_d   = last_q;
      grant_d  = grant_q;
      rdy_d    = 2'b00;
      drop_d   = 2'b00;
      rdata_d  = rdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               state_d = S_ISSUE;
               grant_d = (pend_q == 2'b11) ? ~last_q : pend_q[1];
               last_d  = grant_d;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (ready) begin
               state_d = S_IDLE;
               rdata_d = rdata;
               rdy_d   = done;
               pend_d  = pend_q & ~done;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // a completing port may reload its buffer at the same edge
      for (int i = 0; i < 2; i++) begin
         if (req_transfer[i]) begin
            if (!pend_q[i] || done[i]) begin
               pend_d[i]   = 1'b1;
               baddr_d[i]  = in_addr[i];
               bwdata_d[i] = in_wdata[i];
               bwrite_d[i] = req_write[i];
            end else begin
               drop_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q  <= S_IDLE;
         pend_q   <= '0;
         baddr_q  <= '0;
         bwdata_q <= '0;
         bwrite_q <= '0;
         last_q   <= 1'b1;
         grant_q  <= 1'b0;
         rdy_q    <= '0;
         drop_q   <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         baddr_q  <= baddr_d;
         bwdata_q <= bwdata_d;
         bwrite_q <= bwrite_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         rdy_q    <= rdy_d;
         drop_q   <= drop_d;
         rdata_q  <= rdata_d;
      end
   end

   assign transfer  = (state_q == S_ISSUE);
   assign addr      = baddr_q[grant_q];
   assign wdata     = bwdata_q[grant_q];
   assign write     = bwrite_q[grant_q];
   assign grant     = grant_q;
   assign req_busy  = pend_q;
   assign req_ready = rdy_q;
   assign req_drop  = drop_q;
   assign req_rdata = rdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: randomized and directed stimulus, a request-level
// reference model and a completion scoreboard for apb_req_arbiter.
module tb_apb_req_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          PCLK = 1'b0;
   logic          PRESET = 1'b1;
   logic [1:0]    req_transfer = '0;
   logic [AW-1:0] req_addr0 = '0;
   logic [AW-1:0] req_addr1 = '0;
   logic [DW-1:0] req_wdata0 = '0;
   logic [DW-1:0] req_wdata1 = '0;
   logic [1:0]    req_write = '0;
   logic [1:0]    req_ready;
   logic [DW-1:0] req_rdata;
   logic [1:0]    req_busy;
   logic [1:0]    req_drop;
   logic          transfer;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          write;
   logic          ready = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic          grant;

   int checks = 0;
   int failures = 0;

   apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_transfer(req_transfer),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .req_write(req_write),
      .req_ready(req_ready), .req_rdata(req_rdata),
      .req_busy(req_busy), .req_drop(req_drop),
      .transfer(transfer), .addr(addr), .wdata(wdata), .write(write),
      .ready(ready), .rdata(rdata), .grant(grant)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // reference model: one buffered request per port, round-robin issue
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          w;
   } req_t;
   typedef struct {
      int            port;
      logic [DW-1:0] d;
   } cpl_t;

   req_t          mbuf [2];
   logic [1:0]    mpend = '0;
   logic [1:0]    pend_prev = '0;
   bit            mlast = 1'b1;
   bit            inwait = 1'b0;
   int            wport = 0;
   req_t          wreq;
   cpl_t          sb [$];
   logic [1:0]    exp_drop = '0;
   bit            exp_rdy = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   bit            rst_prev = 1'b1;
   int            cyc = 0;
   int            exp_xfer_cyc = -1;
   int            stall = 0;
   int            grant_log [$];
   logic [AW-1:0] addr_log [$];
   logic [1:0]    rdy_log [$];
   int            rdy_cnt = 0;
   int            drop_cnt = 0;

   // APB master stand-in
   int            slv_lat = -1;
   bit            slv_fix_en = 1'b0;
   logic [DW-1:0] slv_fix = '0;
   bit            stray_req = 1'b0;
   bit            slv_busy = 1'b0;

   initial begin
      int lat;
      forever begin
         @(negedge PCLK);
         if (transfer === 1'b1 && !PRESET) begin
            slv_busy = 1'b1;
            lat = (slv_lat >= 0) ? slv_lat : int'($urandom_range(0, 3));
            repeat (lat) @(posedge PCLK);
            @(posedge PCLK);
            #1;
            ready = 1'b1;
            rdata = slv_fix_en ? slv_fix : $urandom;
            @(posedge PCLK);
            #1;
            ready = 1'b0;
            slv_busy = 1'b0;
         end else if (stray_req) begin
            stray_req = 1'b0;
            slv_busy = 1'b1;
            @(posedge PCLK);
            #1;
            ready = 1'b1;
            rdata = $urandom;
            @(posedge PCLK);
            #1;
            ready = 1'b0;
            slv_busy = 1'b0;
         end
      end
   end

   // monitor: checks this cycle's outputs, then predicts the coming edge
   always @(negedge PCLK) begin
      logic [1:0] pend_now;
      bit         wait_now;
      int         g;
      cpl_t       c;
      cyc++;
      wait_now = inwait;
      pend_now = mpend;
      if (rst_prev) begin
         chk("rst_req_ready", req_ready, 2'b00);
         chk("rst_req_busy", req_busy, 2'b00);
         chk("rst_req_drop", req_drop, 2'b00);
         chk("rst_req_rdata", req_rdata, 0);
         chk("rst_transfer", transfer, 1'b0);
         chk("rst_addr", addr, 0);
         chk("rst_wdata", wdata, 0);
         chk("rst_write", write, 1'b0);
         chk("rst_grant", grant, 1'b0);
      end else begin
         chk("req_drop", req_drop, exp_drop);
         chk("req_busy", req_busy, mpend);
         if (req_drop != 2'b00) drop_cnt++;
         if (req_ready != 2'b00) begin
            rdy_cnt++;
            rdy_log.push_back(req_ready);
            if (sb.size() == 0) begin
               chk("req_ready_spurious", req_ready, 2'b00);
            end else begin
               c = sb.pop_front();
               chk("req_ready_port", req_ready, 2'b01 << c.port);
               chk("req_rdata", req_rdata, c.d);
               m_rdata = c.d;
            end
         end else if (exp_rdy && sb.size() != 0) begin
            c = sb.pop_front();
            chk("req_ready_missing", req_ready, 2'b01 << c.port);
         end
         chk("req_rdata_hold", req_rdata, m_rdata);
         if (wait_now) begin
            chk("hold_addr", addr, wreq.a);
            chk("hold_wdata", wdata, wreq.d);
            chk("hold_write", write, wreq.w);
            chk("transfer_in_wait", transfer, 1'b0);
         end else if (transfer === 1'b1) begin
            if (pend_prev == 2'b00) begin
               chk("transfer_spurious", transfer, 1'b0);
            end else begin
               if (pend_prev == 2'b11) g = mlast ? 0 : 1;
               else g = pend_prev[0] ? 0 : 1;
               mlast = (g == 1);
               chk("issue_grant", grant, g);
               chk("issue_addr", addr, mbuf[g].a);
               chk("issue_wdata", wdata, mbuf[g].d);
               chk("issue_write", write, mbuf[g].w);
               grant_log.push_back(g);
               addr_log.push_back(mbuf[g].a);
               inwait = 1'b1;
               wport = g;
               wreq = mbuf[g];
            end
         end
         if (exp_xfer_cyc == cyc) chk("issue_latency", transfer, 1'b1);
         if (pend_now != 2'b00 && !inwait) stall++;
         else stall = 0;
         if (stall > 10) begin
            chk("issue_timeout", transfer, 1'b1);
            stall = 0;
         end
      end

      if (PRESET) begin
         mpend = '0;
         pend_prev = '0;
         inwait = 1'b0;
         mlast = 1'b1;
         sb.delete();
         exp_drop = '0;
         exp_rdy = 1'b0;
         m_rdata = '0;
         exp_xfer_cyc = -1;
         stall = 0;
      end else begin
         exp_drop = 2'b00;
         exp_rdy = 1'b0;
         if (ready === 1'b1 && wait_now) begin
            c.port = wport;
            c.d = rdata;
            sb.push_back(c);
            exp_rdy = 1'b1;
            mpend[wport] = 1'b0;
            inwait = 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            if (req_transfer[i]) begin
               if (!mpend[i]) begin
                  mbuf[i].a = (i == 0) ? req_addr0 : req_addr1;
                  mbuf[i].d = (i == 0) ? req_wdata0 : req_wdata1;
                  mbuf[i].w = req_write[i];
                  mpend[i] = 1'b1;
                  if (pend_now == 2'b00 && !wait_now)
                     exp_xfer_cyc = cyc + 2;
               end else begin
                  exp_drop[i] = 1'b1;
               end
            end
         end
         pend_prev = pend_now;
      end
      rst_prev = PRESET;
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic pulse(input logic [1:0] p,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [1:0] w);
      req_transfer = p;
      req_addr0 = a0;
      req_addr1 = a1;
      req_wdata0 = d0;
      req_wdata1 = d1;
      req_write = w;
      tick();
      req_transfer = 2'b00;
   endtask

   task automatic wait_xfer();
      int n = 0;
      while (transfer !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) chk("xfer_timeout", n, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(mpend == 2'b00 && !inwait && sb.size() == 0 && !slv_busy)
             && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) chk("idle_timeout", n, 0);
      repeat (2) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "time limit");
   end

   initial begin
      int         n;
      int         issued;
      int         gl0;
      int         dc0;
      int         rc0;
      logic [1:0] p;
      logic [DW-1:0] rd0;

      repeat (3) tick();
      PRESET = 1'b0;
      tick();

      // single read on port 0
      slv_lat = 2;
      slv_fix_en = 1'b1;
      slv_fix = 32'h0000_00A5;
      pulse(2'b01, 32'h1000_4000, 0, 0, 0, 2'b00);
      tick();
      chk("t1_transfer", transfer, 1'b1);
      chk("t1_addr", addr, 32'h1000_4000);
      n = 0;
      while (req_ready == 2'b00 && n < 30) begin
         tick();
         n++;
      end
      chk("t1_req_ready", req_ready, 2'b01);
      chk("t1_req_rdata", req_rdata, 32'h0000_00A5);
      slv_fix_en = 1'b0;
      slv_lat = -1;
      wait_idle();

      // simultaneous requests straight after reset
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      tick();
      pulse(2'b11, 32'h1000_2000, 32'h1000_3000, 32'h55, 32'h0, 2'b01);
      wait_xfer();
      chk("t2_first_grant", grant, 1'b0);
      chk("t2_first_write", write, 1'b1);
      chk("t2_first_wdata", wdata, 32'h55);
      tick();
      wait_xfer();
      chk("t2_second_grant", grant, 1'b1);
      chk("t2_second_addr", addr, 32'h1000_3000);
      chk("t2_second_write", write, 1'b0);
      tick();
      wait_idle();
      if (rdy_log.size() >= 2) begin
         chk("t2_ready_order0", rdy_log[rdy_log.size()-2], 2'b01);
         chk("t2_ready_order1", rdy_log[rdy_log.size()-1], 2'b10);
      end else begin
         chk("t2_ready_count", rdy_log.size(), 2);
      end

      // fairness under saturation
      gl0 = grant_log.size();
      dc0 = drop_cnt;
      pulse(2'b11, $urandom, $urandom, $urandom, $urandom, 2'($urandom));
      issued = 2;
      n = 0;
      while (issued < 6 && n < 200) begin
         p = 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (req_ready[i] && issued < 6) begin
               p[i] = 1'b1;
               issued++;
            end
         end
         if (p != 2'b00)
            pulse(p, $urandom, $urandom, $urandom, $urandom, 2'($urandom));
         else
            tick();
         n++;
      end
      wait_idle();
      if (grant_log.size() >= gl0 + 6) begin
         for (int k = 0; k < 6; k++)
            chk("fair_grant", grant_log[gl0+k], k % 2);
      end else begin
         chk("fair_count", grant_log.size() - gl0, 6);
      end
      chk("fair_no_drop", drop_cnt, dc0);

      // overflow on port 1 while port 0 waits
      slv_lat = 6;
      pulse(2'b01, 32'h1000_0100, 0, 32'h11, 0, 2'b01);
      wait_xfer();
      tick();
      pulse(2'b10, 0, 32'h2000_0010, 0, 32'h22, 2'b00);
      pulse(2'b10, 0, 32'h2000_0020, 0, 32'h33, 2'b10);
      chk("ovf_drop", req_drop, 2'b10);
      wait_idle();
      chk("ovf_addr", addr_log[addr_log.size()-1], 32'h2000_0010);
      slv_lat = -1;

      // reset during WAIT with port 1 pending
      slv_lat = 5;
      pulse(2'b01, 32'h1000_0200, 0, 0, 0, 2'b00);
      wait_xfer();
      tick();
      pulse(2'b10, 0, 32'h2000_0200, 0, 0, 2'b00);
      chk("rst_mid_busy_before", req_busy, 2'b11);
      rc0 = rdy_cnt;
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      chk("rst_mid_busy", req_busy, 2'b00);
      chk("rst_mid_transfer", transfer, 1'b0);
      chk("rst_mid_addr", addr, 0);
      wait_idle();
      repeat (4) tick();
      chk("rst_mid_no_ready", rdy_cnt, rc0);
      slv_lat = -1;

      // stray ready while idle
      pulse(2'b10, 0, 32'h3000_0000, 0, 0, 2'b00);
      wait_idle();
      rd0 = req_rdata;
      rc0 = rdy_cnt;
      stray_req = 1'b1;
      repeat (6) tick();
      chk("stray_no_ready", rdy_cnt, rc0);
      chk("stray_rdata", req_rdata, rd0);

      // randomized traffic
      repeat (400) begin
         p[0] = ($urandom_range(0, 3) == 0);
         p[1] = ($urandom_range(0, 3) == 0);
         if (p != 2'b00)
            pulse(p, $urandom, $urandom, $urandom, $urandom, 2'($urandom));
         else
            tick();
      end
      wait_idle();
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
